// File: rtl/dff_pkg.sv
// Shared defaults for the dff slice.
// Holds the default data width and reset bit pattern.
package dff_pkg;

  localparam int   DFF_WIDTH   = 1;
  localparam logic DFF_RST_BIT = 1'b0;

endpackage

// File: rtl/dff_if.sv
// Data bundle for one dff instance.
// d drives both storage paths; q is edge output, ql latch output.
interface dff_if #(
  parameter int WIDTH = dff_pkg::DFF_WIDTH
);

  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] ql;

  modport master (
    output d,
    input  q,
    input  ql
  );

  modport slave (
    input  d,
    output q,
    output ql
  );

endinterface

// File: rtl/dff_dlatch.sv
// Positive-transparent latch with level reset.
// Ports: clk (enable), rst_n (active-low, honoured while clk=1), d, q.
module dlatch
  import dff_pkg::*;
#(
  parameter int               WIDTH   = DFF_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{DFF_RST_BIT}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reset only acts while open, so a low-phase rst_n pulse
  // leaves the held value alone.
  always_latch begin
    if (clk) begin
      q <= rst_n ? d : RST_VAL;
    end
  end

endmodule

// File: rtl/dff.sv
// Flip-flop plus transparent latch sharing one data input.
// Ports: clk, rst_n (sync, active-low), d, q (edge), ql (latch).
module dff
  import dff_pkg::*;
#(
  parameter int               WIDTH   = DFF_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{DFF_RST_BIT}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] ql
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else begin
      q <= d;
    end
  end

  dlatch #(
    .WIDTH   (WIDTH),
    .RST_VAL (RST_VAL)
  ) u_lat (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (d),
    .q     (ql)
  );

endmodule

// File: tb/tb_dff.sv
// Self-checking bench for dff.
// Covers 1-bit default and 8-bit A5-reset instances.
module tb_dff;

  localparam logic [7:0] R8 = 8'hA5;

  logic clk = 1'b0;
  logic rst_n;
  logic r8;

  int tests = 0;
  int fails = 0;

  dff_if #(.WIDTH(1)) bus1 ();
  dff_if #(.WIDTH(8)) bus8 ();

  always #10 clk = ~clk;

  dff u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus1.d),
    .q     (bus1.q),
    .ql    (bus1.ql)
  );

  dff #(
    .WIDTH   (8),
    .RST_VAL (R8)
  ) u_dut8 (
    .clk   (clk),
    .rst_n (r8),
    .d     (bus8.d),
    .q     (bus8.q),
    .ql    (bus8.ql)
  );

  // Reference: q is the reset-or-data choice seen at each rise;
  // ql while high is that choice live, while low it is the
  // choice seen at the last fall.
  logic       q1_m, h1_m;
  logic [7:0] q8_m, h8_m;

  always @(posedge clk) begin
    q1_m <= rst_n ? bus1.d : 1'b0;
    q8_m <= r8 ? bus8.d : R8;
  end

  always @(negedge clk) begin
    h1_m <= rst_n ? bus1.d : 1'b0;
    h8_m <= r8 ? bus8.d : R8;
  end

  function automatic logic exp_ql1();
    return clk ? (rst_n ? bus1.d : 1'b0) : h1_m;
  endfunction

  function automatic logic [7:0] exp_ql8();
    return clk ? (r8 ? bus8.d : R8) : h8_m;
  endfunction

  task automatic check(input string name,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h at %0t",
               name, got, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_q1"}, {7'd0, bus1.q}, {7'd0, q1_m});
    check({tag, "_ql1"}, {7'd0, bus1.ql}, {7'd0, exp_ql1()});
    check({tag, "_q8"}, bus8.q, q8_m);
    check({tag, "_ql8"}, bus8.ql, exp_ql8());
  endtask

  typedef struct {
    logic       rst;
    logic [7:0] d;
    logic [7:0] q;
    logic [7:0] ql;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b1, 8'hFF, 8'hFF, 8'hFF};
    vecs[1] = '{1'b0, 8'h12, R8,    R8};
    vecs[2] = '{1'b1, 8'h00, 8'h00, 8'h00};
    vecs[3] = '{1'b1, 8'h5A, 8'h5A, 8'h5A};
    vecs[4] = '{1'b0, 8'hC3, R8,    R8};
    vecs[5] = '{1'b1, 8'h81, 8'h81, 8'h81};

    rst_n  = 1'b0;
    r8     = 1'b0;
    bus1.d = 1'b1;
    bus8.d = 8'h3C;

    // Reset held across two rises with d=1.
    repeat (2) @(posedge clk);
    #5;
    check("rst_q1", {7'd0, bus1.q}, 8'h00);
    check("rst_ql1", {7'd0, bus1.ql}, 8'h00);
    check("rst_q8", bus8.q, R8);
    check("rst_ql8", bus8.ql, R8);

    // Release in low phase: ql keeps reset value until high.
    @(negedge clk);
    #5;
    rst_n = 1'b1;
    r8    = 1'b1;
    #1;
    check("rel_ql1_low", {7'd0, bus1.ql}, 8'h00);
    check("rel_q1_low", {7'd0, bus1.q}, 8'h00);
    @(posedge clk);
    #1;
    check("rel_q1", {7'd0, bus1.q}, 8'h01);
    check("rel_ql1", {7'd0, bus1.ql}, 8'h01);
    check("rel_q8", bus8.q, 8'h3C);
    check("rel_ql8", bus8.ql, 8'h3C);

    // Table on the 8-bit instance.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #5;
      r8     = vecs[i].rst;
      bus8.d = vecs[i].d;
      @(posedge clk);
      #3;
      check($sformatf("vec%0d_q8", i), bus8.q, vecs[i].q);
      check($sformatf("vec%0d_ql8", i), bus8.ql, vecs[i].ql);
    end

    // Pulse d inside one high phase; q holds 1.
    @(posedge clk);
    #2;
    bus1.d = 1'b0;
    #1;
    check("pulse_ql_a", {7'd0, bus1.ql}, 8'h00);
    check("pulse_q_a", {7'd0, bus1.q}, 8'h01);
    #2;
    bus1.d = 1'b1;
    #1;
    check("pulse_ql_b", {7'd0, bus1.ql}, 8'h01);
    #2;
    bus1.d = 1'b0;
    #1;
    check("pulse_ql_c", {7'd0, bus1.ql}, 8'h00);
    check("pulse_q_c", {7'd0, bus1.q}, 8'h01);
    @(posedge clk);
    #1;
    check("pulse_q_next", {7'd0, bus1.q}, 8'h00);

    // Low-phase d change is invisible until the rise.
    bus1.d = 1'b1;
    @(posedge clk);
    #1;
    check("hold_q_set", {7'd0, bus1.q}, 8'h01);
    @(negedge clk);
    #3;
    bus1.d = 1'b0;
    #2;
    check("hold_ql", {7'd0, bus1.ql}, 8'h01);
    check("hold_q", {7'd0, bus1.q}, 8'h01);
    @(posedge clk);
    #1;
    check("hold_q_next", {7'd0, bus1.q}, 8'h00);
    check("hold_ql_next", {7'd0, bus1.ql}, 8'h00);

    // Reset during high forces ql; release resumes at once.
    #1;
    bus1.d = 1'b1;
    #1;
    check("hi_rst_ql_d", {7'd0, bus1.ql}, 8'h01);
    rst_n = 1'b0;
    #1;
    check("hi_rst_ql", {7'd0, bus1.ql}, 8'h00);
    rst_n = 1'b1;
    #1;
    check("hi_rel_ql", {7'd0, bus1.ql}, 8'h01);
    check("hi_rel_q", {7'd0, bus1.q}, 8'h00);

    // Reset pulse confined to the low phase changes nothing.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    #1;
    check("lo_rst_q", {7'd0, bus1.q}, 8'h00);
    check("lo_rst_ql", {7'd0, bus1.ql}, 8'h01);
    @(posedge clk);
    #1;
    check("lo_rst_q_next", {7'd0, bus1.q}, 8'h01);

    // d toggling every 15 ns against the 20 ns clock.
    @(posedge clk);
    #3;
    fork
      begin
        repeat (6) begin
          bus1.d = ~bus1.d;
          bus8.d = 8'($urandom);
          #15;
        end
      end
      begin
        #1;
        check_model("slow");
        repeat (15) begin
          #5;
          check_model("slow");
        end
      end
    join

    // Random drive at offsets clear of both edges.
    for (int i = 0; i < 60; i++) begin
      @(clk);
      #($urandom_range(1, 8));
      rst_n  = ($urandom_range(0, 7) != 0);
      r8     = ($urandom_range(0, 7) != 0);
      bus1.d = 1'($urandom);
      bus8.d = 8'($urandom);
      #1;
      check_model("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dff.md
DFF -- requirements
Module: dff

Interface
REQ-001 Parameter WIDTH, default 1: bit width of d, q and ql; SHALL be >= 1.
REQ-002 Parameter RST_VAL, default all-zeros (WIDTH bits): value loaded into q and ql by reset.
REQ-003 One clock; reset is synchronous and active-low.
REQ-004 Port clk, input, 1 bit: the single clock; q samples on its rising edge; ql is transparent while clk=1.
REQ-005 Port rst_n, input, 1 bit: synchronous active-low reset, sampled only as stated under Reset.
REQ-006 Port d, input, WIDTH bits: data input shared by both storage paths.
REQ-007 Port q, output, WIDTH bits: edge-triggered flip-flop output.
REQ-008 Port ql, output, WIDTH bits: level-sensitive latch output.

Function
REQ-009 On each rising clk edge with rst_n=1, q SHALL take the value d had immediately before the edge; latency is one edge.
REQ-010 q SHALL NOT change between rising edges, whatever d, rst_n or the falling clk edge do.
REQ-011 While clk=1 and rst_n=1, ql SHALL follow d combinationally with zero cycle latency.
REQ-012 While clk=0, ql SHALL hold the value d had at the falling clk edge.
REQ-013 When d changes at the same instant as the falling clk edge, ql SHALL hold the pre-edge d.
REQ-014 When d changes at the same instant as the rising clk edge, q SHALL capture the pre-edge d, and ql SHALL then track the new d.
REQ-015 Each bit of q and ql SHALL be independent; there is no arithmetic or cross-bit logic.
REQ-016 Before the first reset or first rising edge, q and ql are X.
REQ-017 Benches SHALL apply a reset before checking any output value.

Reset
REQ-018 On a rising clk edge with rst_n=0, q SHALL become RST_VAL.
REQ-019 While clk=1 and rst_n=0, ql SHALL be RST_VAL.
REQ-020 While clk=0, ql SHALL hold its value; an assertion of rst_n while clk=0 SHALL NOT affect ql.
REQ-021 Deasserting rst_n while clk=1 SHALL make ql resume following d immediately.
REQ-022 After rst_n is deasserted, q SHALL load d on the first rising edge.
REQ-023 If reset is asserted mid-operation, reset SHALL take priority over d on that same edge or level.

Structure
REQ-024 Sub-module dlatch (parameter WIDTH; ports clk, rst_n, d, q): positive-transparent latch implementing REQ-011..013 and REQ-019..021.
REQ-025 dff SHALL instantiate one dlatch driving ql.
REQ-026 dff SHALL build q as a master-slave pair: a master dlatch on inverted clk feeding a slave dlatch on clk, or an equivalent single always_ff.
REQ-027 A shared package SHALL hold the default WIDTH and RST_VAL constants; no typedefs are required.
REQ-028 Reset value and width SHALL come only from parameters, with no hard-coded literals.

Verification
REQ-029 WIDTH=1, clk period 20 ns, rst_n=0 for 2 edges, d=1 -> q=0 and ql=0; release rst_n -> q=1 at the next rising edge.
REQ-030 Setup: rst_n=1, clk=1. Toggle d 0->1->0 within one high phase -> ql pulses 1 then 0; q is unchanged until the next rising edge.
REQ-031 Setup: clk=0, ql holds 1. Drive d=0 during the low phase -> ql stays 1 and q stays 1; at the next rising edge q=0 and ql=0.
REQ-032 d period 30 ns against clk period 20 ns for 80 ns, after reset -> q changes only on rising edges, and ql changes only while clk=1 or at a rising edge.
REQ-033 WIDTH=8, RST_VAL=8'hA5, d=8'h3C, reset for 1 edge -> q=8'hA5; next edge with rst_n=1 -> q=8'h3C.
REQ-034 rst_n pulsed low only while clk=0 -> neither q nor ql changes.
